// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP header constants and transmitter state encoding
package arp_pkg;
  localparam logic [15:0] ARP_HTYPE = 16'h0001;
  localparam logic [15:0] ARP_PTYPE = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP = 16'h0002;
  localparam int ARP_FRAME_BYTES = 46;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, DONE} arp_state_t;
endpackage

// File: rtl/arp_tx.sv
// arp_tx: builds and streams ARP request/reply payloads to the MAC TX arbiter
module arp_tx
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] LOCAL_IP = 32'hc0_a8_00_02,
  parameter int REQ_GAP = 125_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_request_req,
  input  logic [31:0] destination_ip_addr,
  input  logic        arp_reply_req,
  input  logic [31:0] arp_rec_source_ip_addr,
  input  logic [47:0] arp_rec_source_mac_addr,
  output logic        arp_tx_req,
  input  logic        arp_tx_ack,
  output logic [7:0]  arp_tx_data,
  output logic        arp_tx_valid,
  output logic        arp_tx_last,
  input  logic        arp_tx_ready,
  output logic [47:0] arp_tx_dst_mac,
  output logic        arp_tx_done
);
  arp_state_t r_state, w_next;
  logic [5:0] r_idx;
  logic [31:0] r_gap;
  logic r_req_pend, r_rep_pend;
  logic [31:0] r_rep_ip, r_tpa;
  logic [47:0] r_rep_mac, r_tha, r_dst_mac;
  logic [15:0] r_oper;
  logic w_take_rep, w_take_req, w_acc, w_end, w_req_busy;
  logic [5:0] w_rev;
  logic [367:0] w_frame;
  assign w_take_rep = (r_state == IDLE) && r_rep_pend;
  assign w_take_req = (r_state == IDLE) && r_req_pend && !r_rep_pend;
  assign w_acc = (r_state == SEND) && arp_tx_ready;
  assign w_end = w_acc && (r_idx == 6'(ARP_FRAME_BYTES - 1));
  assign w_req_busy = (r_state != IDLE) && (r_oper == ARP_OPER_REQ);
  assign w_rev = 6'(ARP_FRAME_BYTES - 1) - r_idx;
  assign w_frame = {ARP_HTYPE, ARP_PTYPE, 8'h06, 8'h04, r_oper, LOCAL_MAC, LOCAL_IP,
                    r_tha, r_tpa, 144'h0};
  assign arp_tx_dst_mac = r_dst_mac;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Next state and stream outputs; data is forced to zero outside SEND
  always_comb begin
    w_next = r_state;
    arp_tx_req = 1'b0;
    arp_tx_valid = 1'b0;
    arp_tx_last = 1'b0;
    arp_tx_done = 1'b0;
    arp_tx_data = 8'h00;
    case (r_state)
      IDLE: w_next = (r_rep_pend || r_req_pend) ? WAIT_ACK : IDLE;
      WAIT_ACK: begin
        arp_tx_req = 1'b1;
        w_next = arp_tx_ack ? SEND : WAIT_ACK;
      end
      SEND: begin
        arp_tx_valid = 1'b1;
        arp_tx_last = (r_idx == 6'(ARP_FRAME_BYTES - 1));
        arp_tx_data = w_frame[{w_rev, 3'b000} +: 8];
        w_next = w_end ? DONE : SEND;
      end
      default: begin
        arp_tx_done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  // Pending slots, rate-limit counter and per-frame snapshot; a new reply pulse beats the clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_req_pend <= 1'b0;
      r_rep_pend <= 1'b0;
      r_rep_ip <= '0;
      r_rep_mac <= '0;
      r_gap <= '0;
      r_idx <= '0;
      r_oper <= '0;
      r_tha <= '0;
      r_tpa <= '0;
      r_dst_mac <= '0;
    end else begin
      r_rep_pend <= arp_reply_req ? 1'b1 : w_take_rep ? 1'b0 : r_rep_pend;
      r_rep_ip <= arp_reply_req ? arp_rec_source_ip_addr : r_rep_ip;
      r_rep_mac <= arp_reply_req ? arp_rec_source_mac_addr : r_rep_mac;
      r_req_pend <= w_take_req ? 1'b0 :
                    (arp_request_req && r_gap == 0 && !w_req_busy) ? 1'b1 : r_req_pend;
      r_gap <= (w_end && r_oper == ARP_OPER_REQ) ? 32'(REQ_GAP) : (r_gap != 0) ? r_gap - 1 : r_gap;
      r_idx <= (r_state == WAIT_ACK) ? '0 : w_acc ? r_idx + 1 : r_idx;
      if (w_take_rep) begin
        r_oper <= ARP_OPER_REP;
        r_tha <= r_rep_mac;
        r_tpa <= r_rep_ip;
        r_dst_mac <= r_rep_mac;
      end else if (w_take_req) begin
        r_oper <= ARP_OPER_REQ;
        r_tha <= '0;
        r_tpa <= destination_ip_addr;
        r_dst_mac <= '1;
      end
    end
endmodule

// File: tb/tb_arp_tx.sv
// tb_arp_tx: randomized checks of arp_tx frames against a byte-list reference model
module tb_arp_tx;
  localparam logic [47:0] MAC = 48'h00_0a_35_01_fe_c0;
  localparam logic [31:0] IP = 32'hc0_a8_00_02;
  localparam int GAP = 100;
  logic clk = 0, rst = 1;
  logic arp_request_req = 0, arp_reply_req = 0, arp_tx_ack = 0, arp_tx_ready = 0;
  logic [31:0] destination_ip_addr = 0, arp_rec_source_ip_addr = 0;
  logic [47:0] arp_rec_source_mac_addr = 0;
  logic arp_tx_req, arp_tx_valid, arp_tx_last, arp_tx_done;
  logic [7:0] arp_tx_data;
  logic [47:0] arp_tx_dst_mac;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] expb [46];
  int k;
  arp_tx #(.LOCAL_MAC(MAC), .LOCAL_IP(IP), .REQ_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .arp_request_req(arp_request_req),
    .destination_ip_addr(destination_ip_addr), .arp_reply_req(arp_reply_req),
    .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
    .arp_rec_source_mac_addr(arp_rec_source_mac_addr), .arp_tx_req(arp_tx_req),
    .arp_tx_ack(arp_tx_ack), .arp_tx_data(arp_tx_data), .arp_tx_valid(arp_tx_valid),
    .arp_tx_last(arp_tx_last), .arp_tx_ready(arp_tx_ready), .arp_tx_dst_mac(arp_tx_dst_mac),
    .arp_tx_done(arp_tx_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      expb[k] = v[8*i +: 8];
      k++;
    end
  endtask
  task automatic build(input logic [15:0] oper, input logic [47:0] tha, input logic [31:0] tpa);
    k = 0;
    push(64'h0001, 2);
    push(64'h0800, 2);
    push(64'h06, 1);
    push(64'h04, 1);
    push(64'(oper), 2);
    push(64'(MAC), 6);
    push(64'(IP), 4);
    push(64'(tha), 6);
    push(64'(tpa), 4);
    while (k < 46) push(64'h0, 1);
  endtask
  task automatic wait_req(input int limit, output int req_c);
    int n = 0;
    while (!arp_tx_req && n < limit) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(arp_tx_req), 64'h1);
    req_c = cyc;
  endtask
  // mode: 0 ready high, 1 ready toggling, 2 random ready
  task automatic frame(input logic [15:0] oper, input logic [47:0] tha, input logic [31:0] tpa,
                       input logic [47:0] dst, input int mode, input int ackd, input int limit,
                       output int req_c, output int done_c);
    int cnt = 0, guard = 0;
    logic held = 0, tg = 1;
    logic [7:0] hd = 0;
    build(oper, tha, tpa);
    wait_req(limit, req_c);
    chk("dst_mac", 64'(arp_tx_dst_mac), 64'(dst));
    for (int i = 0; i < ackd; i++) begin
      tick();
      chk("req_hold", {62'h0, arp_tx_req, arp_tx_valid}, 64'h2);
    end
    arp_tx_ack = 1;
    tick();
    arp_tx_ack = 0;
    chk("valid_after_ack", {62'h0, arp_tx_valid, arp_tx_req}, 64'h2);
    while (cnt < 46 && guard < 2000) begin
      arp_tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tg : 1'($urandom_range(0, 1));
      tg = ~tg;
      if (held) chk("stable", 64'(arp_tx_data), 64'(hd));
      held = 0;
      if (arp_tx_valid && arp_tx_ready) begin
        chk($sformatf("byte%0d", cnt), 64'(arp_tx_data), 64'(expb[cnt]));
        if (arp_tx_last || cnt == 45) chk("last", 64'(arp_tx_last), 64'(cnt == 45));
        cnt++;
      end else if (arp_tx_valid) begin
        held = 1;
        hd = arp_tx_data;
      end
      tick();
      guard++;
    end
    arp_tx_ready = 0;
    chk("byte_count", 64'(cnt), 64'd46);
    chk("done_pulse", {62'h0, arp_tx_done, arp_tx_valid}, 64'h2);
    done_c = cyc;
    tick();
    chk("done_drop", 64'(arp_tx_done), 64'h0);
  endtask
  initial begin
    int rq, dn, prev_dn, cnt, dcount;
    logic [31:0] rip;
    logic [47:0] rmac;
    repeat (3) tick();
    chk("rst_out", {arp_tx_req, arp_tx_valid, arp_tx_last, arp_tx_done, arp_tx_data, arp_tx_dst_mac},
        64'h0);
    rst = 0;
    tick();
    destination_ip_addr = 32'hc0a80003;
    arp_request_req = 1;
    frame(16'h0001, 48'h0, 32'hc0a80003, '1, 0, 3, 20, rq, dn);
    arp_request_req = 0;
    arp_rec_source_ip_addr = 32'hc0a80005;
    arp_rec_source_mac_addr = 48'h001122334455;
    arp_reply_req = 1;
    tick();
    arp_reply_req = 0;
    frame(16'h0002, 48'h001122334455, 32'hc0a80005, 48'h001122334455, 0, 1, 20, rq, dn);
    for (int t = 0; t < 2; t++) begin
      rip = $urandom;
      rmac = {16'($urandom), 32'($urandom)};
      arp_rec_source_ip_addr = rip;
      arp_rec_source_mac_addr = rmac;
      arp_reply_req = 1;
      tick();
      arp_reply_req = 0;
      arp_rec_source_ip_addr = $urandom;
      frame(16'h0002, rmac, rip, rmac, t + 1, $urandom_range(0, 4), 20, rq, dn);
    end
    repeat (GAP + 10) tick();
    rip = $urandom;
    rmac = {16'($urandom), 32'($urandom)};
    arp_rec_source_ip_addr = rip;
    arp_rec_source_mac_addr = rmac;
    destination_ip_addr = $urandom;
    arp_reply_req = 1;
    arp_request_req = 1;
    tick();
    arp_reply_req = 0;
    frame(16'h0002, rmac, rip, rmac, 2, 2, 20, rq, dn);
    frame(16'h0001, 48'h0, destination_ip_addr, '1, 2, 0, 20, rq, prev_dn);
    for (int f = 0; f < 3; f++) begin
      frame(16'h0001, 48'h0, destination_ip_addr, '1, 0, $urandom_range(0, 3), GAP * 4, rq, dn);
      chk("gap_spacing", 64'(rq - prev_dn >= GAP), 64'h1);
      prev_dn = dn;
    end
    arp_request_req = 0;
    repeat (GAP + 10) tick();
    destination_ip_addr = 32'hc0a8000a;
    arp_request_req = 1;
    wait_req(20, rq);
    arp_request_req = 0;
    arp_tx_ack = 1;
    tick();
    arp_tx_ack = 0;
    arp_tx_ready = 1;
    cnt = 0;
    while (cnt < 20) begin
      if (arp_tx_valid) cnt++;
      tick();
    end
    #2 rst = 1;
    #1;
    chk("rst_mid", {arp_tx_req, arp_tx_valid, arp_tx_last, arp_tx_done, arp_tx_data, arp_tx_dst_mac},
        64'h0);
    arp_tx_ready = 0;
    tick();
    tick();
    rst = 0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dcount += int'(arp_tx_done) + int'(arp_tx_valid);
    end
    chk("no_done_after_rst", 64'(dcount), 64'h0);
    destination_ip_addr = 32'hc0a8000b;
    arp_request_req = 1;
    frame(16'h0001, 48'h0, 32'hc0a8000b, '1, 2, 1, 20, rq, dn);
    arp_request_req = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arp_tx.md
ARP_TX -- requirements
Module: arp_tx

Interface
REQ-001 SHALL have parameter LOCAL_MAC, 48'h00_0a_35_01_fe_c0, own MAC placed in SHA.
REQ-002 SHALL have parameter LOCAL_IP, 32'hc0_a8_00_02, own IP placed in SPA.
REQ-003 SHALL have parameter REQ_GAP, 125_000_000, minimum cycles between two ARP requests.
REQ-004 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port arp_request_req  in  1  level, destination MAC unknown (driven from mac_not_exist).
REQ-006 SHALL have port destination_ip_addr  in  32  IP to resolve (TPA of request).
REQ-007 SHALL have port arp_reply_req  in  1  one-cycle pulse, received request targets LOCAL_IP.
REQ-008 SHALL have ports arp_rec_source_ip_addr  in  32 and arp_rec_source_mac_addr  in  48, requester identity for replies, valid with arp_reply_req.
REQ-009 SHALL have ports arp_tx_req  out  1  frame-slot request to MAC TX arbiter; arp_tx_ack  in  1  one-cycle grant.
REQ-010 SHALL have ports arp_tx_data  out  8, arp_tx_valid  out  1, arp_tx_last  out  1, arp_tx_ready  in  1 (byte stream to MAC TX).
REQ-011 SHALL have port arp_tx_dst_mac  out  48  Ethernet destination for the frame being sent.
REQ-012 SHALL have port arp_tx_done  out  1  one-cycle pulse after last byte accepted.

Function
REQ-013 SHALL use states IDLE, WAIT_ACK, SEND, DONE.
REQ-014 SHALL latch arp_reply_req with its IP/MAC into a one-deep reply-pending slot; a second pulse while pending overwrites it.
REQ-015 SHALL raise request-pending when arp_request_req=1 and the gap counter has expired; counter reloads to REQ_GAP when a request frame completes and counts down to 0.
REQ-016 SHALL in IDLE, when any pending, snapshot opcode and target fields, clear that pending flag, go to WAIT_ACK; reply wins if both pending.
REQ-017 SHALL hold arp_tx_req=1 throughout WAIT_ACK; on arp_tx_ack go to SEND with byte index 0; arp_tx_valid rises the cycle after ack.
REQ-018 SHALL emit 46 bytes: 0x00,0x01, 0x08,0x00, 0x06, 0x04, 0x00,OPER, SHA[47:40..7:0], SPA[31:24..7:0], THA, TPA, then 18 bytes 0x00, MSB first.
REQ-019 SHALL use OPER=1, THA=0, TPA=destination_ip_addr, arp_tx_dst_mac=48'hff_ff_ff_ff_ff_ff for requests.
REQ-020 SHALL use OPER=2, THA=latched requester MAC, TPA=latched requester IP, arp_tx_dst_mac=latched requester MAC for replies.
REQ-021 SHALL advance byte index only when arp_tx_valid & arp_tx_ready; data/valid/last held stable otherwise.
REQ-022 SHALL assert arp_tx_last with byte 45 only; on its acceptance go to DONE, drop valid.
REQ-023 SHALL in DONE pulse arp_tx_done for one cycle, then return to IDLE; back-to-back frames therefore separated by at least 2 idle cycles.
REQ-024 SHALL keep snapshot fields constant during SEND regardless of input changes.
REQ-025 SHALL still latch new arp_reply_req while busy; served after return to IDLE.

Reset
REQ-026 SHALL on rst=1 force IDLE, clear both pending flags, gap counter to 0, arp_tx_req/valid/last/done to 0, arp_tx_data to 0, arp_tx_dst_mac to 0, independent of clk.
REQ-027 SHALL abandon any frame in progress on reset mid-frame; no arp_tx_done issued for it.

Structure
REQ-028 SHALL take ARP_HTYPE (16'h0001), ARP_PTYPE (16'h0800), ARP_OPER_REQ/REP, ARP_FRAME_BYTES (46) from shared package arp_pkg.
REQ-029 SHALL be a single module; byte selection is an in-module index mux, no sub-module.

Verification
REQ-030 SHALL check request: REQ_GAP=100, arp_request_req=1, dest IP c0a80003, ack after 3 cycles, ready=1 -> 46 bytes 00 01 08 00 06 04 00 01 + LOCAL_MAC + LOCAL_IP + 6x00 + c0 a8 00 03 + 18x00, last on byte 46, dst_mac ff..ff, done pulse.
REQ-031 SHALL check reply: pulse with IP c0a80005, MAC 001122334455 -> OPER 00 02, THA/dst_mac 001122334455, TPA c0a80005.
REQ-032 SHALL check backpressure: ready toggled 1/0 each cycle -> identical byte sequence, data stable while ready=0, 46 accepted bytes.
REQ-033 SHALL check rate limit: arp_request_req held high 300 cycles, REQ_GAP=100 -> frame starts spaced >=100 cycles after previous done.
REQ-034 SHALL check priority: reply pulse and request same cycle -> reply frame first, request frame next.
REQ-035 SHALL check reset at byte 20 -> outputs zero immediately, no done, next request sends full 46-byte frame.
